// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the MIPS fetch stage
package mips_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

    localparam logic [1:0] FAULT_NONE  = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE = 2'b10;

    typedef enum logic [1:0] {
        ST_WAIT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/mips_next_pc.sv
// rtl/mips_next_pc.sv - combinational next-PC mux and PC fault check
module mips_next_pc
    import mips_pkg::*;
#(
    parameter int IMEM_DEPTH = 1024
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] if_id_pc4_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [25:0]     jump_index_i,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            fault_o,
    output logic [1:0]      fault_code_o
);

    localparam logic [XLEN-1:0] DEPTH_W = 32'(IMEM_DEPTH);

    logic [XLEN-1:0] word_idx;

    assign word_idx   = {2'b00, pc_i[XLEN-1:2]};
    assign pc_plus4_o = pc_i + 32'd4;
    assign redirect_o = branch_taken_i | jump_i;

    // Jump region comes from the instruction in decode, i.e. the IF/ID PC+4.
    assign redirect_pc_o = branch_taken_i ? branch_target_i
                                          : {if_id_pc4_i[31:28], jump_index_i, 2'b00};

    always_comb begin
        fault_o      = 1'b0;
        fault_code_o = FAULT_NONE;
        if (pc_i[1:0] != 2'b00) begin
            fault_o      = 1'b1;
            fault_code_o = FAULT_ALIGN;
        end else if (word_idx >= DEPTH_W) begin
            fault_o      = 1'b1;
            fault_code_o = FAULT_RANGE;
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// rtl/mips_fetch_unit.sv - PC register, IF/ID pipeline register and fetch FSM
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
    output logic [1:0]  fault_code,
    output logic [31:0] fetch_count
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc4_q;
    logic            valid_q;
    logic [1:0]      fault_q;
    logic [XLEN-1:0] count_q;

    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] pc_plus4;
    logic            fault;
    logic [1:0]      fault_code_d;

    mips_next_pc #(.IMEM_DEPTH(IMEM_DEPTH)) u_next_pc (
        .pc_i           (pc_q),
        .if_id_pc4_i    (pc4_q),
        .branch_taken_i (branch_taken),
        .branch_target_i(branch_target),
        .jump_i         (jump),
        .jump_index_i   (jump_index),
        .redirect_o     (redirect),
        .redirect_pc_o  (redirect_pc),
        .pc_plus4_o     (pc_plus4),
        .fault_o        (fault),
        .fault_code_o   (fault_code_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= FAULT_NONE;
            count_q <= '0;
        end else begin
            case (state_q)
                ST_WAIT: state_q <= ST_RUN;
                ST_RUN: begin
                    // Redirect beats stall and flush; stall also masks the fault check.
                    if (redirect) begin
                        pc_q    <= redirect_pc;
                        instr_q <= NOP;
                        pc4_q   <= '0;
                        valid_q <= 1'b0;
                    end else if (stall) begin
                        pc_q <= pc_q;
                    end else if (flush) begin
                        instr_q <= NOP;
                        pc4_q   <= '0;
                        valid_q <= 1'b0;
                    end else if (fault) begin
                        state_q <= ST_HALT;
                        fault_q <= fault_code_d;
                        instr_q <= NOP;
                        pc4_q   <= '0;
                        valid_q <= 1'b0;
                    end else begin
                        instr_q <= imem_data;
                        pc4_q   <= pc_plus4;
                        valid_q <= 1'b1;
                        pc_q    <= pc_plus4;
                        count_q <= count_q + 32'd1;
                    end
                end
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_HALT;
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign halted      = (state_q == ST_HALT);
    assign fault_code  = fault_q;
    assign fetch_count = count_q;

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the combinational instruction memory.
- Owns the PC register and drives the byte address to imem (imem indexes words as addr>>2).
- Captures the returned word into the IF/ID pipeline register for the decoder.
- Applies stall, flush, branch and jump redirects; halts with a fault code on a misaligned or out-of-range PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_DEPTH, 1024, number of 32-bit words in instruction memory; legal PCs are 0 .. IMEM_DEPTH*4-4

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
stall  input  1  hold PC and IF/ID (hazard unit)
flush  input  1  insert bubble into IF/ID; PC held
branch_taken  input  1  decode resolved a taken branch
branch_target  input  32  byte target for branch
jump  input  1  decode has a J-type jump
jump_index  input  26  instr_index field of the jump
imem_addr  output  32  byte address to instruction memory (= pc, combinational)
imem_data  input  32  instruction word from memory
if_id_instr  output  32  registered instruction
if_id_pc4  output  32  registered PC+4 of that instruction
if_id_valid  output  1  IF/ID holds a real instruction
halted  output  1  block is in HALT
fault_code  output  2  00 none, 01 misaligned PC, 10 PC beyond IMEM_DEPTH
fetch_count  output  32  count of instructions delivered to IF/ID

Behaviour:
- Reset state (async on rst_n low):
  - pc = RESET_PC; if_id_instr = 0 (NOP); if_id_pc4 = 0; if_id_valid = 0.
  - halted = 0; fault_code = 00; fetch_count = 0; FSM = WAIT.
- imem_addr = pc at all times, including WAIT and HALT. Memory is combinational: the word is usable in the same cycle.
- FSM state WAIT: the first clk edge after rst_n rises moves to RUN. No fetch, no state change otherwise.
- FSM state RUN: per-edge priority, highest first:
  1. Redirect (branch_taken or jump):
     - pc <= branch_taken ? branch_target : {if_id_pc4[31:28], jump_index, 2'b00}.
     - branch_taken wins if both are asserted.
     - IF/ID <= bubble (instr 0, valid 0, pc4 0).
     - Overrides stall and flush.
  2. Stall: pc, IF/ID and fetch_count all hold. Fault checks are suppressed.
  3. Flush: IF/ID <= bubble; pc holds.
  4. Fault check on current pc:
     - pc[1:0] != 0 -> HALT, fault_code 01.
     - else (pc>>2) >= IMEM_DEPTH -> HALT, fault_code 10.
     - IF/ID <= bubble in both cases.
  5. Normal fetch:
     - if_id_instr <= imem_data; if_id_pc4 <= pc+4; if_id_valid <= 1.
     - pc <= pc+4; fetch_count <= fetch_count+1.
- Misaligned redirect targets are loaded into pc and then trap via rule 4 on the next non-stalled, non-redirect, non-flush edge.
- FSM state HALT:
  - halted = 1; pc, fault_code and fetch_count frozen; if_id_valid = 0.
  - All inputs ignored; only rst_n exits.
- Arithmetic:
  - pc+4 wraps modulo 2^32 (it reaches the range fault first when IMEM_DEPTH < 2^30).
  - fetch_count wraps 2^32-1 -> 0.
- Reset asserted mid-operation clears everything immediately, independent of clk.
- Latency: an instruction at address A appears on if_id_instr one edge after pc = A is accepted. Branch penalty is 1 bubble.

Decomposition:
- Shared package (mips_pkg):
  - NOP constant 32'h0000_0000.
  - Fault code localparams FAULT_NONE/FAULT_ALIGN/FAULT_RANGE.
  - FSM state encoding WAIT/RUN/HALT.
  - Width constant XLEN=32.
- One natural sub-module: mips_next_pc. It is the combinational next-PC mux covering branch, jump-address formation, pc+4 and the fault check.
- The FSM, IF/ID register and counter stay in the top level.

Test Plan:
- Sequential fetch:
  - Stimulus: reset, release; imem holds 0x00008020 @0, 0x2011000a @4.
  - Required: edge 1 WAIT->RUN; edge 2 if_id_instr=0x00008020, if_id_pc4=4, valid=1; edge 3 0x2011000a, pc4=8; fetch_count=2.
- Jump:
  - Stimulus: if_id_pc4=0x28, jump=1, jump_index=6.
  - Required: pc=0x18 next edge; IF/ID bubble (valid 0); following edge if_id_pc4=0x1C.
- Branch+stall+jump together:
  - Stimulus: branch_taken=1, branch_target=0x44, jump=1, stall=1.
  - Required: pc=0x44; bubble; fetch_count unchanged.
- Stall/flush:
  - Stimulus: stall for 3 cycles at pc=0x10.
  - Required: pc and if_id outputs constant, imem_addr=0x10.
  - Stimulus: then flush alone.
  - Required: valid=0, pc still 0x10.
- Faults:
  - Stimulus: branch_target=0x6.
  - Required: next fetch edge halted=1, fault_code=01, pc=0x6 frozen.
  - Stimulus: with IMEM_DEPTH=4, run to pc=0x10.
  - Required: fault_code=10 after 4 fetches, fetch_count=4.
- Async reset:
  - Stimulus: drop rst_n mid-cycle while in HALT.
  - Required: outputs return to reset values before the next edge; fault_code=00.
